pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready flow control.
// Groups of GROUP bits resolve per rank; each rank forwards the pending upper operand bits.

module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    logic [GROUP-1:0] p, g;
    logic [GROUP:0]   c;
    logic             pp;

    // Each carry is a flat sum of generate terms masked by the propagate run above them.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        pp   = 1'b1;
        c[0] = cin;
        for (int i = 1; i <= GROUP; i++) begin
            pp   = 1'b1;
            c[i] = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & pp);
                pp   = pp & p[j];
            end
            c[i] = c[i] | (pp & cin);
        end
    end

    assign s    = p ^ c[GROUP-1:0];
    assign cout = c[GROUP];
    assign cmsb = c[GROUP-1];
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic [WIDTH:0]   out
);
    localparam int N   = WIDTH / GROUP;
    localparam int GPS = N / STAGES;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [STAGES:1]                  vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0]     a_q, b_q, s_q;
    logic [STAGES-1:0]                c_q, m_q;

    logic [STAGES-1:0][WIDTH-1:0]     a_n, b_n, s_n;
    logic [STAGES-1:0]                c_n, m_n, v_up;
    logic                             adv [STAGES];

    logic [WIDTH-1:0] b_eff, gsum;
    logic             cin_eff;
    logic             gci [N];
    logic             gco [N];
    logic [N-1:0]     gcm;
    logic             unused_ok;

    // Subtract folds into the adder as A + ~B + 1.
    assign b_eff   = sub ? ~B : B;
    assign cin_eff = sub | Cin;

    for (genvar g = 0; g < N; g++) begin : g_grp
        localparam int K = g / GPS;
        logic [GROUP-1:0] ga, gb;
        if (K == 0) begin : g_in
            assign ga = A[g*GROUP +: GROUP];
            assign gb = b_eff[g*GROUP +: GROUP];
        end else begin : g_rank
            assign ga = a_q[K-1][g*GROUP +: GROUP];
            assign gb = b_q[K-1][g*GROUP +: GROUP];
        end
        if (g % GPS != 0) begin : g_chain
            assign gci[g] = gco[g-1];
        end else if (K == 0) begin : g_cin
            assign gci[g] = cin_eff;
        end else begin : g_creg
            assign gci[g] = c_q[K-1];
        end
        cla_group #(.GROUP(GROUP)) u_grp (
            .a    (ga),
            .b    (gb),
            .cin  (gci[g]),
            .s    (gsum[g*GROUP +: GROUP]),
            .cout (gco[g]),
            .cmsb (gcm[g])
        );
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_rank
        localparam logic [WIDTH-1:0] MHI = ONES >> (WIDTH - (k + 1) * GPS * GROUP);
        localparam logic [WIDTH-1:0] MLO = ONES >> (WIDTH - k * GPS * GROUP);
        assign c_n[k] = gco[(k+1)*GPS-1];
        if (k == 0) begin : g_first
            assign v_up[k] = in_valid;
            assign a_n[k]  = A;
            assign b_n[k]  = b_eff;
            assign s_n[k]  = gsum & MHI;
        end else begin : g_next
            assign v_up[k] = vld_pipe[k];
            assign a_n[k]  = a_q[k-1];
            assign b_n[k]  = b_q[k-1];
            assign s_n[k]  = (gsum & MHI & ~MLO) | (s_q[k-1] & MLO);
        end
        // The MSB lives in the last group, so its carry-in is only known in the last rank.
        if (k == STAGES - 1) begin : g_mlast
            assign m_n[k] = gcm[N-1];
            assign adv[k] = ~vld_pipe[k+1] | out_ready;
        end else begin : g_mmid
            assign m_n[k] = (k == 0) ? 1'b0 : m_q[k-1];
            assign adv[k] = ~vld_pipe[k+1] | adv[k+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            m_q      <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld_pipe[k+1] <= v_up[k];
                    if (v_up[k]) begin
                        a_q[k] <= a_n[k];
                        b_q[k] <= b_n[k];
                        s_q[k] <= s_n[k];
                        c_q[k] <= c_n[k];
                        m_q[k] <= m_n[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_pipe[STAGES];
    assign S         = s_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
    assign ovf       = m_q[STAGES-1] ^ c_q[STAGES-1];
    assign out       = {Cout, S};

    // Last-rank operands and inner-group MSB carries have no consumer.
    assign unused_ok = ^{a_q, b_q, gcm};
endmodule
